// File: rtl/tbuf_drive_pkg.sv
// rtl/tbuf_drive_pkg.sv - shared types and limits for the tristate bus drive controller
package tbuf_drive_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_TURN  = 2'd2
    } tbuf_state_t;

    localparam int CNT_W     = 4;
    localparam int PARAM_MIN = 1;
    localparam int PARAM_MAX = 15;

    function automatic bit param_ok(input int v);
        return (v >= PARAM_MIN) && (v <= PARAM_MAX);
    endfunction

endpackage

// File: rtl/tbuf_drive_rst_sync.sv
// rtl/tbuf_drive_rst_sync.sv - two-flop reset release synchroniser, asynchronous assert
module tbuf_drive_rst_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_rst_n
);

    logic [1:0] r_sync;

    // clear at once on reset, shift ones in after release so deassertion is clock-aligned
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], 1'b1};
        end
    end

    assign o_rst_n = r_sync[1];

endmodule

// File: rtl/tbuf_drive_ctrl.sv
// rtl/tbuf_drive_ctrl.sv - tristate bus drive controller with turnaround, keeper view and contention check
module tbuf_drive_ctrl
    import tbuf_drive_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DRIVE_CYC  = 2,
    parameter int TURNAROUND = 1
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             REQ,
    input  logic [WIDTH-1:0] DIN,
    input  logic [WIDTH-1:0] BUS_I,
    output logic             T,
    output logic [WIDTH-1:0] O,
    output logic             ACK,
    output logic             BUSY,
    output logic [WIDTH-1:0] KEEP_VAL,
    output logic             CONTENTION
);

    generate
        if (!param_ok(DRIVE_CYC) || !param_ok(TURNAROUND)) begin : g_bad_param
            $error("tbuf_drive_ctrl: DRIVE_CYC and TURNAROUND must lie within 1..15");
        end
    endgenerate

    localparam logic [CNT_W-1:0] LP_DRV_LD  = CNT_W'(DRIVE_CYC - 1);
    localparam logic [CNT_W-1:0] LP_TURN_LD = CNT_W'(TURNAROUND - 1);

    logic             w_rst_n;
    tbuf_state_t      r_state;
    tbuf_state_t      w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_load;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_keep;
    logic             r_t;
    logic             r_cont;

    tbuf_drive_rst_sync u_rst_sync (
        .i_clk   (CLK),
        .i_rst_n (RSTN),
        .o_rst_n (w_rst_n)
    );

    // FSM state and shared drive/turnaround down-counter
    always_ff @(posedge CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // next state: accept only in IDLE, count down DRIVE then TURN
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (REQ) begin
                    w_state_nxt = ST_DRIVE;
                    w_cnt_nxt   = LP_DRV_LD;
                    w_load      = 1'b1;
                end
            end
            ST_DRIVE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_TURN;
                    w_cnt_nxt   = LP_TURN_LD;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_TURN: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // pad control, latched data, keeper view and registered contention compare
    always_ff @(posedge CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_t    <= 1'b1;
            r_data <= '0;
            r_keep <= '0;
            r_cont <= 1'b0;
        end else begin
            r_t <= (w_state_nxt != ST_DRIVE);
            if (w_load) begin
                r_data <= DIN;
            end
            if (r_state == ST_DRIVE) begin
                r_keep <= r_data;
            end
            // first drive cycle is skipped while the pad settles
            r_cont <= (r_state == ST_DRIVE) && (r_cnt != LP_DRV_LD) && (BUS_I != r_data);
        end
    end

    assign T          = r_t;
    assign O          = r_data;
    assign ACK        = (r_state == ST_DRIVE) && (r_cnt == '0);
    assign BUSY       = (r_state != ST_IDLE);
    assign KEEP_VAL   = r_keep;
    assign CONTENTION = r_cont;

endmodule

// File: tb/tb_tbuf_drive_ctrl.sv
// tb/tb_tbuf_drive_ctrl.sv - randomized scoreboard bench for tbuf_drive_ctrl across three parameter sets
module tb_tbuf_drive_ctrl;

    localparam int W  = 8;
    localparam int NI = 3;
    localparam int N  = 400;
    localparam int NA = N + 40;
    localparam int D0 = 2;
    localparam int T0 = 1;
    localparam int D1 = 3;
    localparam int T1 = 2;
    localparam int D2 = 1;
    localparam int T2 = 1;

    typedef struct {
        int           cyc;
        logic [W-1:0] data;
    } ack_t;

    logic         CLK = 1'b0;
    logic         RSTN;
    logic         req     [NI];
    logic [W-1:0] din     [NI];
    logic [W-1:0] bus_i   [NI];
    logic         t_w     [NI];
    logic [W-1:0] o_w     [NI];
    logic         ack_w   [NI];
    logic         busy_w  [NI];
    logic [W-1:0] keep_w  [NI];
    logic         cont_w  [NI];

    logic         s_req   [NI][NA];
    logic [W-1:0] s_din   [NI][NA];
    logic [W-1:0] s_bus   [NI][NA];
    bit           acc     [NI][NA];
    bit           e_t     [NI][NA];
    bit           e_busy  [NI][NA];
    bit           e_drv   [NI][NA];
    bit           e_first [NI][NA];
    bit           e_cont  [NI][NA];
    bit           e_kchk  [NI][NA];
    logic [W-1:0] e_o     [NI][NA];
    logic [W-1:0] e_keep  [NI][NA];

    ack_t ack_q [NI][$];

    int n_tests    = 0;
    int n_fail     = 0;
    int cur_k      = -1;
    bit run_active = 1'b0;

    always #5 CLK = ~CLK;

    tbuf_drive_ctrl #(.WIDTH(W), .DRIVE_CYC(D0), .TURNAROUND(T0)) u_dut0 (
        .CLK(CLK), .RSTN(RSTN), .REQ(req[0]), .DIN(din[0]), .BUS_I(bus_i[0]),
        .T(t_w[0]), .O(o_w[0]), .ACK(ack_w[0]), .BUSY(busy_w[0]),
        .KEEP_VAL(keep_w[0]), .CONTENTION(cont_w[0]));

    tbuf_drive_ctrl #(.WIDTH(W), .DRIVE_CYC(D1), .TURNAROUND(T1)) u_dut1 (
        .CLK(CLK), .RSTN(RSTN), .REQ(req[1]), .DIN(din[1]), .BUS_I(bus_i[1]),
        .T(t_w[1]), .O(o_w[1]), .ACK(ack_w[1]), .BUSY(busy_w[1]),
        .KEEP_VAL(keep_w[1]), .CONTENTION(cont_w[1]));

    tbuf_drive_ctrl #(.WIDTH(W), .DRIVE_CYC(D2), .TURNAROUND(T2)) u_dut2 (
        .CLK(CLK), .RSTN(RSTN), .REQ(req[2]), .DIN(din[2]), .BUS_I(bus_i[2]),
        .T(t_w[2]), .O(o_w[2]), .ACK(ack_w[2]), .BUSY(busy_w[2]),
        .KEEP_VAL(keep_w[2]), .CONTENTION(cont_w[2]));

    function automatic int dcyc(input int i);
        case (i)
            0:       return D0;
            1:       return D1;
            default: return D2;
        endcase
    endfunction

    function automatic int tcyc(input int i);
        case (i)
            0:       return T0;
            1:       return T1;
            default: return T2;
        endcase
    endfunction

    task automatic chk(input string nm, input int i, input int k,
                       input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d cyc%0d: got %0h expected %0h", nm, i, k, act, exp);
        end
    endtask

    // Transfer-level reference: each accepted request owns D drive cycles then TA
    // released cycles, and the next request can only be taken after that window.
    task automatic build_model(input int i);
        int           d;
        int           ta;
        int           free_at;
        logic [W-1:0] data;
        logic [W-1:0] kdata;
        d       = dcyc(i);
        ta      = tcyc(i);
        free_at = 0;
        data    = '0;
        kdata   = '0;
        for (int k = 0; k < NA; k++) begin
            acc[i][k] = 0; e_t[i][k] = 1; e_busy[i][k] = 0; e_drv[i][k] = 0;
            e_first[i][k] = 0; e_cont[i][k] = 0; e_kchk[i][k] = 0;
            e_o[i][k] = '0; e_keep[i][k] = '0;
            s_req[i][k] = 0; s_din[i][k] = '0; s_bus[i][k] = '0;
        end
        for (int k = 0; k < N; k++) begin
            s_din[i][k] = W'($urandom);
            s_req[i][k] = ($urandom_range(0, 99) < 40);
            if (k < 12) s_req[i][k] = 0;
            if (k == 2) begin
                s_req[i][k] = 1;
                s_din[i][k] = (i == 0) ? 8'hA5 : (i == 1) ? 8'hFF : 8'h81;
            end
            if (i == 0 && (k == 4 || k == 5)) begin
                s_req[i][k] = 1;
                s_din[i][k] = 8'h55;
            end
            if (i == 0 && k >= 20 && k < 40) begin
                s_req[i][k] = 1;
                s_din[i][k] = 8'h3C;
            end
            e_o[i][k]   = data;
            s_bus[i][k] = ($urandom_range(0, 99) < 30) ? W'($urandom) : data;
            if (i == 1 && k >= 3 && k <= 5) s_bus[i][k] = 8'h00;
            if (e_drv[i][k] && !e_first[i][k]) e_cont[i][k+1] = (s_bus[i][k] != data);
            e_kchk[i][k] = !e_drv[i][k];
            e_keep[i][k] = kdata;
            if (s_req[i][k] && k >= free_at) begin
                acc[i][k] = 1;
                data      = s_din[i][k];
                kdata     = s_din[i][k];
                for (int j = 1; j <= d; j++) begin
                    e_t[i][k+j]    = 0;
                    e_busy[i][k+j] = 1;
                    e_drv[i][k+j]  = 1;
                end
                e_first[i][k+1] = 1;
                for (int j = 1; j <= ta; j++) e_busy[i][k+d+j] = 1;
                free_at = k + d + ta + 1;
            end
        end
    endtask

    task automatic check_cycle(input int i, input int k);
        bit   exp_ack;
        ack_t e;
        chk("t", i, k, t_w[i], e_t[i][k]);
        chk("busy", i, k, busy_w[i], e_busy[i][k]);
        chk("o", i, k, o_w[i], e_o[i][k]);
        chk("contention", i, k, cont_w[i], e_cont[i][k]);
        if (e_kchk[i][k]) chk("keep_val", i, k, keep_w[i], e_keep[i][k]);
        exp_ack = (ack_q[i].size() > 0) && (ack_q[i][0].cyc == k);
        chk("ack", i, k, ack_w[i], exp_ack);
        if (exp_ack) begin
            e = ack_q[i].pop_front();
            chk("ack_data", i, k, o_w[i], e.data);
        end
    endtask

    // monitor: compares every DUT output mid-cycle and retires ACK expectations
    initial begin
        forever begin
            @(negedge CLK);
            if (run_active) begin
                for (int i = 0; i < NI; i++) check_cycle(i, cur_k);
            end
        end
    end

    initial begin
        ack_t e;
        RSTN = 1'b0;
        for (int i = 0; i < NI; i++) begin
            req[i] = 1'b0; din[i] = '0; bus_i[i] = '0;
        end
        repeat (3) @(posedge CLK);
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("rst_t", i, -1, t_w[i], 1);
            chk("rst_o", i, -1, o_w[i], 0);
            chk("rst_ack", i, -1, ack_w[i], 0);
            chk("rst_busy", i, -1, busy_w[i], 0);
            chk("rst_keep", i, -1, keep_w[i], 0);
            chk("rst_cont", i, -1, cont_w[i], 0);
        end
        RSTN = 1'b1;
        repeat (4) @(posedge CLK);
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("post_rst_t", i, -1, t_w[i], 1);
            chk("post_rst_busy", i, -1, busy_w[i], 0);
        end
        for (int i = 0; i < NI; i++) build_model(i);

        for (int k = 0; k < N; k++) begin
            @(posedge CLK);
            #1;
            cur_k = k;
            for (int i = 0; i < NI; i++) begin
                req[i]   = s_req[i][k];
                din[i]   = s_din[i][k];
                bus_i[i] = s_bus[i][k];
                if (acc[i][k]) begin
                    e.cyc  = k + dcyc(i);
                    e.data = s_din[i][k];
                    ack_q[i].push_back(e);
                end
            end
            run_active = 1'b1;
        end
        @(posedge CLK);
        #1;
        run_active = 1'b0;
        for (int i = 0; i < NI; i++) begin
            req[i] = 1'b0; bus_i[i] = '0;
        end
        repeat (20) @(posedge CLK);

        // asynchronous reset during the first drive cycle
        #1;
        req[0] = 1'b1;
        din[0] = 8'h96;
        @(posedge CLK);
        #1;
        req[0] = 1'b0;
        chk("mid_pre_t", 0, -2, t_w[0], 0);
        chk("mid_pre_o", 0, -2, o_w[0], 8'h96);
        #2;
        RSTN = 1'b0;
        #1;
        chk("mid_rst_t", 0, -2, t_w[0], 1);
        chk("mid_rst_o", 0, -2, o_w[0], 0);
        chk("mid_rst_ack", 0, -2, ack_w[0], 0);
        chk("mid_rst_busy", 0, -2, busy_w[0], 0);
        @(posedge CLK);
        #1;
        chk("mid_hold_ack", 0, -2, ack_w[0], 0);
        RSTN = 1'b1;
        repeat (4) @(posedge CLK);
        #1;
        chk("mid_after_busy", 0, -2, busy_w[0], 0);
        chk("mid_after_t", 0, -2, t_w[0], 1);
        chk("mid_after_ack", 0, -2, ack_w[0], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
